// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// Module   : free_list
// Purpose  : Circular queue of free physical register IDs. It grants up to two
//            IDs to rename and accepts up to two releases per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module free_list #(
    parameter  int PRN   = 64,
    parameter  int ARN   = 32,
    parameter  int DEPTH = PRN - ARN,
    localparam int PRW   = $clog2(PRN),
    localparam int QW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          alloc_req,
    output logic [1:0]          alloc_rdy,
    output logic [1:0][PRW-1:0] alloc_preg,
    input  logic [1:0]          release_en,
    input  logic [1:0][PRW-1:0] release_preg,
    output logic [QW:0]         free_cnt,
    output logic                err_overflow,
    output logic                err_underflow
);

    localparam logic [QW:0]   c_depth      = (QW+1)'(DEPTH);
    localparam logic [QW+1:0] c_depth_wide = (QW+2)'(DEPTH);

    logic [PRW-1:0] r_q [DEPTH];
    logic [QW-1:0]  r_head;
    logic [QW-1:0]  r_tail;
    logic [QW:0]    r_cnt;
    logic           r_err_ovf;
    logic           r_err_unf;

    logic [QW-1:0]  w_head_p1;
    logic [QW-1:0]  w_slot1_idx;
    logic           w_grant0;
    logic           w_grant1;
    logic           w_acc0;
    logic           w_acc1;
    logic [1:0]     w_n_alloc;
    logic [1:0]     w_n_rel;
    logic           w_unf;
    logic           w_ovf;

    assign w_head_p1     = r_head + QW'(1);
    assign alloc_preg[0] = r_q[r_head];
    assign alloc_preg[1] = r_q[w_head_p1];
    assign alloc_rdy[0]  = (r_cnt != '0);
    assign alloc_rdy[1]  = (r_cnt > (QW+1)'(1));

    // Slot 1 is only granted together with slot 0.
    assign w_grant0  = alloc_req[0] & alloc_rdy[0];
    assign w_grant1  = w_grant0 & alloc_req[1] & alloc_rdy[1];
    assign w_n_alloc = {1'b0, w_grant0} + {1'b0, w_grant1};
    assign w_unf     = (alloc_req[0] & ~alloc_rdy[0]) | (alloc_req[1] & ~alloc_rdy[1]);

    // Room is judged against the registered count only; same-cycle allocs do not free space.
    assign w_acc0      = release_en[0] & (r_cnt < c_depth);
    assign w_acc1      = release_en[1] & (({1'b0, r_cnt} + (QW+2)'(w_acc0)) < c_depth_wide);
    assign w_n_rel     = {1'b0, w_acc0} + {1'b0, w_acc1};
    assign w_slot1_idx = w_acc0 ? (r_tail + QW'(1)) : r_tail;
    assign w_ovf       = (release_en[0] & ~w_acc0) | (release_en[1] & ~w_acc1);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= PRW'(ARN + i);
            end
            r_head    <= '0;
            r_tail    <= '0;
            r_cnt     <= c_depth;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            if (w_acc0) begin
                r_q[r_tail] <= release_preg[0];
            end
            if (w_acc1) begin
                r_q[w_slot1_idx] <= release_preg[1];
            end
            r_head    <= r_head + QW'(w_n_alloc);
            r_tail    <= r_tail + QW'(w_n_rel);
            r_cnt     <= r_cnt - (QW+1)'(w_n_alloc) + (QW+1)'(w_n_rel);
            r_err_ovf <= r_err_ovf | w_ovf;
            r_err_unf <= r_err_unf | w_unf;
        end
    end

    assign free_cnt      = r_cnt;
    assign err_overflow  = r_err_ovf;
    assign err_underflow = r_err_unf;

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_free_list
// Purpose  : Directed self-checking bench for free_list (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_free_list;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      alloc_req = '0;
    logic [1:0]      alloc_rdy;
    logic [1:0][5:0] alloc_preg;
    logic [1:0]      release_en = '0;
    logic [1:0][5:0] release_preg = '0;
    logic [5:0]      free_cnt;
    logic            err_overflow;
    logic            err_underflow;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    free_list dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_rdy    (alloc_rdy),
        .alloc_preg   (alloc_preg),
        .release_en   (release_en),
        .release_preg (release_preg),
        .free_cnt     (free_cnt),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow)
    );

    // Pointer/count consistency, sampled mid-cycle.
    logic [4:0] inv_diff;
    logic       inv_ok;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            inv_diff = dut.r_tail - dut.r_head;
            inv_ok   = (dut.r_cnt == 6'd32) ? (inv_diff == 5'd0) : (dut.r_cnt == {1'b0, inv_diff});
            vectors++;
            if (inv_ok !== 1'b1) begin
                miscompares++;
                $display("FAIL invariant: cnt=%0d tail=%0d head=%0d", dut.r_cnt, dut.r_tail, dut.r_head);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req    = 2'b00;
        release_en   = 2'b00;
        release_preg = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (alloc_rdy !== 2'b11) begin miscompares++; $display("FAIL reset_rdy: got %b expected 11", alloc_rdy); end
        vectors++; if (alloc_preg[0] !== 6'd32) begin miscompares++; $display("FAIL reset_preg0: got %0d expected 32", alloc_preg[0]); end
        vectors++; if (alloc_preg[1] !== 6'd33) begin miscompares++; $display("FAIL reset_preg1: got %0d expected 33", alloc_preg[1]); end
        vectors++; if (free_cnt !== 6'd32) begin miscompares++; $display("FAIL reset_cnt: got %0d expected 32", free_cnt); end
        vectors++; if ({err_overflow, err_underflow} !== 2'b00) begin miscompares++; $display("FAIL reset_err: got %b expected 00", {err_overflow, err_underflow}); end
        alloc_req = 2'b10;
        step();
        idle();
        vectors++; if (free_cnt !== 6'd32) begin miscompares++; $display("FAIL req10_cnt: got %0d expected 32", free_cnt); end
        vectors++; if (alloc_preg[0] !== 6'd32) begin miscompares++; $display("FAIL req10_preg0: got %0d expected 32", alloc_preg[0]); end
        vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL req10_unf: got %b expected 0", err_underflow); end
    endtask

    task automatic test_drain();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            vectors++; if (alloc_preg[0] !== 6'(32 + 2*k)) begin miscompares++; $display("FAIL drain_preg0[%0d]: got %0d expected %0d", k, alloc_preg[0], 32 + 2*k); end
            vectors++; if (alloc_preg[1] !== 6'(33 + 2*k)) begin miscompares++; $display("FAIL drain_preg1[%0d]: got %0d expected %0d", k, alloc_preg[1], 33 + 2*k); end
            vectors++; if (free_cnt !== 6'(32 - 2*k)) begin miscompares++; $display("FAIL drain_cnt[%0d]: got %0d expected %0d", k, free_cnt, 32 - 2*k); end
            alloc_req = 2'b11;
            step();
        end
        idle();
        vectors++; if (free_cnt !== 6'd0) begin miscompares++; $display("FAIL drain_empty_cnt: got %0d expected 0", free_cnt); end
        vectors++; if (alloc_rdy !== 2'b00) begin miscompares++; $display("FAIL drain_empty_rdy: got %b expected 00", alloc_rdy); end
        vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL drain_unf_pre: got %b expected 0", err_underflow); end
        alloc_req = 2'b01;
        step();
        idle();
        vectors++; if (err_underflow !== 1'b1) begin miscompares++; $display("FAIL drain_unf: got %b expected 1", err_underflow); end
        vectors++; if (free_cnt !== 6'd0) begin miscompares++; $display("FAIL drain_unf_cnt: got %0d expected 0", free_cnt); end
    endtask

    task automatic test_release_empty();
        vectors++; if (alloc_rdy !== 2'b00) begin miscompares++; $display("FAIL rel_pre_rdy: got %b expected 00", alloc_rdy); end
        release_en      = 2'b11;
        release_preg[0] = 6'd40;
        release_preg[1] = 6'd50;
        step();
        idle();
        vectors++; if (alloc_rdy !== 2'b11) begin miscompares++; $display("FAIL rel_rdy: got %b expected 11", alloc_rdy); end
        vectors++; if (free_cnt !== 6'd2) begin miscompares++; $display("FAIL rel_cnt: got %0d expected 2", free_cnt); end
        vectors++; if (alloc_preg[0] !== 6'd40) begin miscompares++; $display("FAIL rel_preg0: got %0d expected 40", alloc_preg[0]); end
        vectors++; if (alloc_preg[1] !== 6'd50) begin miscompares++; $display("FAIL rel_preg1: got %0d expected 50", alloc_preg[1]); end
        alloc_req = 2'b01;
        step();
        vectors++; if (alloc_preg[0] !== 6'd50) begin miscompares++; $display("FAIL rel_next_preg0: got %0d expected 50", alloc_preg[0]); end
        vectors++; if (free_cnt !== 6'd1) begin miscompares++; $display("FAIL rel_next_cnt: got %0d expected 1", free_cnt); end
        vectors++; if (alloc_rdy !== 2'b01) begin miscompares++; $display("FAIL rel_next_rdy: got %b expected 01", alloc_rdy); end
        step();
        idle();
        vectors++; if (free_cnt !== 6'd0) begin miscompares++; $display("FAIL rel_drained_cnt: got %0d expected 0", free_cnt); end
        vectors++; if (alloc_rdy !== 2'b00) begin miscompares++; $display("FAIL rel_drained_rdy: got %b expected 00", alloc_rdy); end
    endtask

    task automatic test_partial_grant();
        do_reset();
        alloc_req = 2'b11;
        repeat (15) step();
        alloc_req = 2'b01;
        step();
        idle();
        vectors++; if (free_cnt !== 6'd1) begin miscompares++; $display("FAIL part_cnt1: got %0d expected 1", free_cnt); end
        vectors++; if (alloc_rdy !== 2'b01) begin miscompares++; $display("FAIL part_rdy: got %b expected 01", alloc_rdy); end
        vectors++; if (alloc_preg[0] !== 6'd63) begin miscompares++; $display("FAIL part_preg0: got %0d expected 63", alloc_preg[0]); end
        vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL part_unf_pre: got %b expected 0", err_underflow); end
        alloc_req = 2'b11;
        step();
        idle();
        vectors++; if (free_cnt !== 6'd0) begin miscompares++; $display("FAIL part_cnt0: got %0d expected 0", free_cnt); end
        vectors++; if (alloc_rdy !== 2'b00) begin miscompares++; $display("FAIL part_rdy0: got %b expected 00", alloc_rdy); end
        vectors++; if (err_underflow !== 1'b1) begin miscompares++; $display("FAIL part_unf: got %b expected 1", err_underflow); end
    endtask

    task automatic test_overflow();
        do_reset();
        release_en      = 2'b01;
        release_preg[0] = 6'd5;
        step();
        idle();
        vectors++; if (err_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b expected 1", err_overflow); end
        vectors++; if (free_cnt !== 6'd32) begin miscompares++; $display("FAIL ovf_cnt: got %0d expected 32", free_cnt); end
        vectors++; if (alloc_preg[0] !== 6'd32 || alloc_preg[1] !== 6'd33) begin miscompares++; $display("FAIL ovf_preg: got %0d,%0d expected 32,33", alloc_preg[0], alloc_preg[1]); end
        release_en      = 2'b01;
        release_preg[0] = 6'd5;
        alloc_req       = 2'b11;
        step();
        idle();
        vectors++; if (free_cnt !== 6'd30) begin miscompares++; $display("FAIL ovf_alloc_cnt: got %0d expected 30", free_cnt); end
        vectors++; if (alloc_preg[0] !== 6'd34 || alloc_preg[1] !== 6'd35) begin miscompares++; $display("FAIL ovf_alloc_preg: got %0d,%0d expected 34,35", alloc_preg[0], alloc_preg[1]); end
    endtask

    task automatic test_overflow_partial();
        do_reset();
        alloc_req = 2'b11;
        step();
        idle();
        release_en      = 2'b10;
        release_preg[1] = 6'd7;
        step();
        idle();
        vectors++; if (free_cnt !== 6'd31) begin miscompares++; $display("FAIL opart_cnt31: got %0d expected 31", free_cnt); end
        vectors++; if (err_overflow !== 1'b0) begin miscompares++; $display("FAIL opart_ovf0: got %b expected 0", err_overflow); end
        release_en      = 2'b11;
        release_preg[0] = 6'd8;
        release_preg[1] = 6'd9;
        step();
        idle();
        vectors++; if (free_cnt !== 6'd32) begin miscompares++; $display("FAIL opart_cnt32: got %0d expected 32", free_cnt); end
        vectors++; if (err_overflow !== 1'b1) begin miscompares++; $display("FAIL opart_ovf1: got %b expected 1", err_overflow); end
        alloc_req = 2'b11;
        repeat (15) step();
        idle();
        vectors++; if (free_cnt !== 6'd2) begin miscompares++; $display("FAIL opart_cnt2: got %0d expected 2", free_cnt); end
        vectors++; if (alloc_preg[0] !== 6'd7 || alloc_preg[1] !== 6'd8) begin miscompares++; $display("FAIL opart_order: got %0d,%0d expected 7,8", alloc_preg[0], alloc_preg[1]); end
    endtask

    task automatic test_back_to_back();
        int exp_q[$];
        do_reset();
        alloc_req = 2'b11;
        repeat (4) step();
        idle();
        vectors++; if (free_cnt !== 6'd24) begin miscompares++; $display("FAIL b2b_start_cnt: got %0d expected 24", free_cnt); end
        for (int i = 8; i < 32; i++) exp_q.push_back(32 + i);
        for (int c = 0; c < 100; c++) begin
            alloc_req       = 2'b11;
            release_en      = 2'b11;
            release_preg[0] = 6'(2*c);
            release_preg[1] = 6'(2*c + 1);
            vectors++; if (alloc_preg[0] !== 6'(exp_q[0]) || alloc_preg[1] !== 6'(exp_q[1])) begin miscompares++; $display("FAIL b2b_preg[%0d]: got %0d,%0d expected %0d,%0d", c, alloc_preg[0], alloc_preg[1], exp_q[0], exp_q[1]); end
            step();
            vectors++; if (free_cnt !== 6'd24) begin miscompares++; $display("FAIL b2b_cnt[%0d]: got %0d expected 24", c, free_cnt); end
            void'(exp_q.pop_front());
            void'(exp_q.pop_front());
            exp_q.push_back((2*c) % 64);
            exp_q.push_back((2*c + 1) % 64);
        end
        idle();
    endtask

    task automatic test_rst_mid();
        do_reset();
        release_en      = 2'b01;
        release_preg[0] = 6'd5;
        step();
        idle();
        alloc_req = 2'b11;
        repeat (12) step();
        alloc_req = 2'b01;
        step();
        idle();
        vectors++; if (free_cnt !== 6'd7) begin miscompares++; $display("FAIL rstmid_pre_cnt: got %0d expected 7", free_cnt); end
        vectors++; if (err_overflow !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_ovf: got %b expected 1", err_overflow); end
        rst             = 1'b1;
        alloc_req       = 2'b11;
        release_en      = 2'b11;
        release_preg[0] = 6'd1;
        release_preg[1] = 6'd2;
        step();
        rst = 1'b0;
        idle();
        vectors++; if (free_cnt !== 6'd32) begin miscompares++; $display("FAIL rstmid_cnt: got %0d expected 32", free_cnt); end
        vectors++; if (alloc_preg[0] !== 6'd32 || alloc_preg[1] !== 6'd33) begin miscompares++; $display("FAIL rstmid_preg: got %0d,%0d expected 32,33", alloc_preg[0], alloc_preg[1]); end
        vectors++; if ({err_overflow, err_underflow} !== 2'b00) begin miscompares++; $display("FAIL rstmid_err: got %b expected 00", {err_overflow, err_underflow}); end
        vectors++; if (alloc_rdy !== 2'b11) begin miscompares++; $display("FAIL rstmid_rdy: got %b expected 11", alloc_rdy); end
        step();
        vectors++; if (free_cnt !== 6'd32) begin miscompares++; $display("FAIL rstmid_hold_cnt: got %0d expected 32", free_cnt); end
    endtask

    initial begin
        test_reset();
        test_drain();
        test_release_empty();
        test_partial_grant();
        test_overflow();
        test_overflow_partial();
        test_back_to_back();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/free_list.md
# free_list

Physical-register free list for the rename stage: a circular queue of unallocated physical register IDs that hands up to two IDs per cycle to rename and accepts up to two released IDs per cycle. Releases come from the reorder buffer: stale registers at retirement, and speculative registers during rollback. The free list sits between the ROB's release outputs and the rename/issue logic. It is instantiated once for the general-purpose register file and once, with smaller parameters, for the T-flag registers.

## Interface
- PRN, 64, total physical registers; ID width PRW = $clog2(PRN)
- ARN, 32, architectural registers; physical IDs 0..ARN-1 start out mapped and are never initially free
- DEPTH, PRN-ARN, queue depth; must be a power of two; pointer width QW = $clog2(DEPTH)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alloc_req  in  2  rename requests IDs; slot 1 is valid only with slot 0
- alloc_rdy  out  2  [0]: at least 1 ID free; [1]: at least 2 IDs free
- alloc_preg  out  2xPRW  IDs offered this cycle; [0] is the oldest free entry
- release_en  in  2  return ID(s) to the list (ROB retire_en / retire_t_en)
- release_preg  in  2xPRW  IDs being returned
- free_cnt  out  QW+1  number of free IDs, 0..DEPTH
- err_overflow  out  1  sticky: a release was dropped because the queue was full
- err_underflow  out  1  sticky: alloc_req was asserted without the matching alloc_rdy

## Operation
- State: storage array q[DEPTH] of PRW-bit IDs, head and tail pointers (QW bits, wrap modulo DEPTH), count cnt (QW+1 bits).
- Reset: q[i] = ARN+i for i in 0..DEPTH-1; head = tail = 0; cnt = DEPTH; both error flags = 0.
- Offered IDs: alloc_preg[0] = q[head] and alloc_preg[1] = q[head+1], read combinationally from registered state.
- Ready: alloc_rdy[0] = (cnt >= 1) and alloc_rdy[1] = (cnt >= 2), both from registered cnt only.
- Allocation count nA:
  - nA = 1 when alloc_req[0] & alloc_rdy[0].
  - nA = 2 when, in addition, alloc_req[1] & alloc_rdy[1].
  - alloc_req = 2'b10 allocates nothing.
  - head advances by nA.
- Denied requests: a request denied for lack of ready sets err_underflow; head and cnt are unaffected by that slot.
- Release ordering: enabled slots are written in slot order starting at tail.
  - 2'b11: q[tail] = preg[0], q[tail+1] = preg[1].
  - 2'b01 or 2'b10: the single enabled ID goes to q[tail].
  - tail advances by the number written, nR.
- Full-queue protection: a release is accepted only while cnt + accepted-so-far (within the cycle, slot 0 first) + 0 < DEPTH. Counting allocations of the same cycle does not create room; the check uses registered cnt. Each dropped release sets err_overflow, and tail does not advance for it.
- Count update: cnt_next = cnt - nA + nR, with no other adjustment.
- Invariant: cnt equals (tail - head) mod DEPTH, except that cnt = DEPTH when the pointers are equal and the queue is full. The bench checks this every cycle.
- No ID validity checking: duplicate or architectural-range IDs are accepted as given. The ROB is responsible for releasing each ID exactly once.
- Rollback: the ROB returns speculative IDs through release_en, so the free list needs no rollback input. Alloc and release proceed independently every cycle.

## Timing
- Allocation is zero-latency: alloc_preg is valid in the same cycle as alloc_rdy, and the ID is consumed at the clock edge where alloc_req & alloc_rdy.
- A released ID becomes allocatable no earlier than the cycle after its release edge. It is allocatable then only if it is next at head, i.e. when the queue was empty.
- Same-cycle alloc and release: both take effect at the same edge. A release never forwards to alloc_preg in the same cycle.
- Empty queue (cnt = 0): alloc_rdy = 2'b00, alloc_preg holds stale data, and releases still proceed.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble, and a 2-wide access may straddle the wrap (e.g. head = DEPTH-1 uses q[DEPTH-1] and q[0]).
- rst mid-operation: all state returns to the reset image at the next edge, and same-cycle requests and releases are ignored.
- Outputs after reset (default parameters): alloc_rdy = 2'b11, alloc_preg = {33, 32}, free_cnt = 32, err_* = 0.

## Test plan
- Reset then alloc_req = 2'b11 for 16 cycles -> IDs 32..63 are handed out in order, free_cnt = 0, alloc_rdy = 2'b00; one more request -> err_underflow = 1.
- From empty, release 40 and 50 together, then alloc_req = 2'b01 for 2 cycles -> alloc_preg[0] is 40, then 50; alloc_rdy = 2'b00 until the release edge.
- With free_cnt = 1, issue alloc_req = 2'b11 -> only slot 0 is granted, free_cnt = 0, err_underflow = 1.
- Full queue (after reset): release_en = 2'b01 with ID 5 -> dropped, err_overflow = 1, free_cnt stays 32; same-cycle alloc of 2 still yields {33, 32}.
- Steady state: alloc 2 and release 2 each cycle for 100 cycles, spanning several pointer wraps -> free_cnt is constant, allocation order matches release order, and the invariant holds.
- Assert rst while free_cnt = 7 with alloc and release active -> the next cycle shows free_cnt = 32, alloc_preg = {33, 32}, and both error flags cleared.
